// File: rtl/threedeeohpad_reader_if.sv
// Pad-link bundle between a 3DO pad reader and its environment.
// The slave side is the reader; the master side drives the request and
// the pad data line and observes the pad strobes and the assembled frame.
interface threedeeohpad_reader_if #(
    parameter int BITS = 16
);
    logic            start;
    logic            dat;
    logic            ps;
    logic            clk_out;
    logic            busy;
    logic            valid;
    logic [BITS-1:0] data;

    modport master (
        output start,
        output dat,
        input  ps,
        input  clk_out,
        input  busy,
        input  valid,
        input  data
    );

    modport slave (
        input  start,
        input  dat,
        output ps,
        output clk_out,
        output busy,
        output valid,
        output data
    );
endinterface

// File: rtl/threedeeohpad_reader.sv
// Console-side 3DO pad reader: strobes ps, toggles clk_out and samples the
// pad data line, assembling one BITS-wide frame (first bit = MSB) per start.
// The pad drives inverted bits, so the stored bit is the inverse of dat.
module threedeeohpad_reader #(
    parameter int BITS        = 16,
    parameter int HALF_PERIOD = 50
) (
    input  logic                   system_clock,
    input  logic                   reset,
    threedeeohpad_reader_if.slave  link
);
    localparam int DIV_W = $clog2(HALF_PERIOD);
    localparam int CNT_W = $clog2(BITS);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(HALF_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LATCH_LO = 3'd1;
    localparam logic [2:0] ST_LATCH_HI = 3'd2;
    localparam logic [2:0] ST_BIT_LO   = 3'd3;
    localparam logic [2:0] ST_BIT_HI   = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [2:0]      state_r;
    logic [2:0]      state_nxt_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] bit_cnt_nxt_s;
    logic [BITS-1:0] shift_r;
    logic [BITS-1:0] shift_nxt_s;
    logic            dat_meta_r;
    logic            dat_sync_r;
    logic            ps_r;
    logic            clk_out_r;
    logic            busy_r;
    logic            valid_r;
    logic [BITS-1:0] data_r;

    // Two-flop synchroniser for the asynchronous pad data line; idles high like an absent pad.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            dat_meta_r <= link.dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Next-state logic: every timed phase runs the divider from HALF_PERIOD-1 down to 0.
    always_comb begin
        state_nxt_s   = state_r;
        div_nxt_s     = div_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shift_nxt_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (link.start) begin
                    state_nxt_s   = ST_LATCH_LO;
                    div_nxt_s     = DIV_LOAD;
                    bit_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_LATCH_LO: begin
                if (div_r == DIV_ZERO) begin
                    state_nxt_s = ST_LATCH_HI;
                    div_nxt_s   = DIV_LOAD;
                end else begin
                    div_nxt_s   = div_r - DIV_ONE;
                end
            end
            ST_LATCH_HI: begin
                if (div_r == DIV_ZERO) begin
                    state_nxt_s = ST_BIT_LO;
                    div_nxt_s   = DIV_LOAD;
                end else begin
                    div_nxt_s   = div_r - DIV_ONE;
                end
            end
            ST_BIT_LO: begin
                // Sample as late as possible so both synchronisers have settled.
                if (div_r == DIV_ZERO) begin
                    shift_nxt_s = {shift_r[BITS-2:0], ~dat_sync_r};
                    state_nxt_s = ST_BIT_HI;
                    div_nxt_s   = DIV_LOAD;
                end else begin
                    div_nxt_s   = div_r - DIV_ONE;
                end
            end
            ST_BIT_HI: begin
                if (div_r == DIV_ZERO) begin
                    if (bit_cnt_r == CNT_LAST) begin
                        state_nxt_s   = ST_DONE;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                        state_nxt_s   = ST_BIT_LO;
                        div_nxt_s     = DIV_LOAD;
                    end
                end else begin
                    div_nxt_s = div_r - DIV_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state: FSM, divider, bit counter and shift register.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            div_r     <= DIV_ZERO;
            bit_cnt_r <= CNT_ZERO;
            shift_r   <= {BITS{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            div_r     <= div_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Registered pad strobes and host status, decoded from the current state.
    always_ff @(posedge system_clock) begin
        if (reset) begin
            ps_r      <= 1'b0;
            clk_out_r <= 1'b1;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            data_r    <= {BITS{1'b0}};
        end else begin
            ps_r      <= (state_r == ST_LATCH_LO) || (state_r == ST_LATCH_HI);
            clk_out_r <= !((state_r == ST_LATCH_LO) || (state_r == ST_BIT_LO));
            busy_r    <= (state_r != ST_IDLE);
            valid_r   <= (state_r == ST_DONE);
            if (state_r == ST_DONE) begin
                data_r <= shift_r;
            end else begin
                data_r <= data_r;
            end
        end
    end

    assign link.ps      = ps_r;
    assign link.clk_out = clk_out_r;
    assign link.busy    = busy_r;
    assign link.valid   = valid_r;
    assign link.data    = data_r;
endmodule

// File: doc/threedeeohpad_reader.md
# threedeeohpad_reader

Console-side reader for the 3DO controller serial interface. It drives the pad's parallel-strobe and shift-clock lines and samples the pad's data line. The sampled bits are assembled into a parallel word, one full frame per request. It sits on the host side of a pad link and is the counterpart to the pad-emulation block. It is used to test the pad emulator and to read real 3DO pads into the adapter.

## Interface
- BITS, 16: frame length in bits; minimum 2.
- HALF_PERIOD, 50: system_clock cycles per half period of clk_out; minimum 8, so the sample point clears both 2-flop synchronisers.

- system_clock  input  1  sole clock; everything is on its rising edge.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  input  1  request one frame read; sampled only in IDLE.
- dat  input  1  pad data line, asynchronous; passed through a 2-flop synchroniser (dat_s) before use.
- ps  output  1  parallel/serial strobe to the pad; registered.
- clk_out  output  1  shift clock to the pad; registered.
- busy  output  1  high in every state except IDLE.
- valid  output  1  one-cycle pulse when data is updated.
- data  output  BITS  last complete frame; first bit received is the MSB.

## Operation
- Reset values: ps=0, clk_out=1, busy=0, valid=0, data=0, shift register=0, bit counter=0, divider=0, state=IDLE. The synchroniser flops reset to 1.
- Divider: loads HALF_PERIOD-1 on entry to each timed state and decrements to 0. A timed state lasts exactly HALF_PERIOD cycles.
- IDLE: ps=0, clk_out=1. If start=1, go to LATCH_LO and clear the bit counter.
- LATCH_LO: ps=1, clk_out=0. After HALF_PERIOD cycles go to LATCH_HI.
- LATCH_HI: ps=1, clk_out=1. The pad latches its inputs on this rising edge. After HALF_PERIOD cycles go to BIT_LO.
- BIT_LO: ps=0, clk_out=0. On the last cycle of the phase (divider=0), shift = {shift[BITS-2:0], ~dat_s}. The pad drives the inverted bit, so the stored bit equals the pad's input bit. Then go to BIT_HI.
- BIT_HI: ps=0, clk_out=1. The pad shifts on this rising edge. After HALF_PERIOD cycles:
  - if bit counter = BITS-1, go to DONE;
  - otherwise increment the bit counter and go to BIT_LO.
- DONE: lasts one cycle with ps=0, clk_out=1. data <= shift, valid=1. Next state is IDLE.
- start is ignored in every state except IDLE, including DONE. There is no queueing.
- data holds its value between frames and changes only in DONE.
- Reset asserted mid-frame aborts the frame:
  - all outputs return to reset values on the next edge;
  - no valid pulse is produced for the aborted frame;
  - data is cleared to 0.
- A pad that is absent reads dat=1 (pull-up), so the frame completes normally with data=0.

## Timing
- valid is high exactly (2+2·BITS)·HALF_PERIOD + 1 cycles after the edge that samples start in IDLE.
  - BITS=16, HALF_PERIOD=50: 1701 cycles.
- busy rises on the edge after start is sampled. It falls on the edge after the valid cycle.
- The earliest back-to-back start is the cycle after valid. IDLE lasts at least one cycle.
- ps=1 for exactly 2·HALF_PERIOD cycles per frame.
- clk_out produces exactly BITS+1 rising edges per frame: 1 latch edge plus BITS shift edges.
- Bit sampling happens on the cycle with divider=0 in BIT_LO. That is HALF_PERIOD-1 cycles after the clk_out falling edge, which covers the pad's 2-cycle input synchroniser plus the reader's 2-cycle dat synchroniser.
- ps and clk_out never change in the same cycle except at these transitions:
  - entry to LATCH_LO (ps rises with the clk_out fall);
  - LATCH_HI→BIT_LO (ps falls with the clk_out fall).

## Test plan
- Loopback with the pad emulator model, pad inputs = 16'hA5C3, start pulsed once:
  - data=16'hA5C3, single valid pulse at cycle 1701;
  - busy high for 1701 cycles.
- Loopback with pad inputs 16'hFFFF, then 16'h0001, on consecutive frames (start the cycle after valid) → data=16'hFFFF, then data=16'h0001. Exactly 2 valid pulses.
- dat held at 1 (no pad) → data=16'h0000 and valid still pulses. dat held at 0 → data=16'hFFFF.
- start held high continuously for 5000 cycles:
  - frames run back-to-back with 1 IDLE cycle between them;
  - start during busy never shortens or restarts a frame;
  - 2 valid pulses within the first 3404 cycles.
- Reset asserted at cycle 900 of a frame:
  - next cycle ps=0, clk_out=1, busy=0, data=0;
  - no valid pulse;
  - a fresh start then yields a correct frame.
- Waveform check with HALF_PERIOD=8, BITS=4:
  - ps high for 16 cycles, 5 clk_out rising edges;
  - valid at cycle (2+8)·8+1=81.
